// File: rtl/mcu51_pkg.sv
// Shared 8051 external-bus definitions: fetch state encoding, bus idle levels and widths.
package mcu51_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [DATA_W-1:0] PORT_IDLE = 8'hFF;
    localparam logic              PSEN_OFF  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LATCH  = 3'd2,
        ST_STROBE = 3'd3,
        ST_DONE   = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/xcode_fetch_if.sv
// Control-unit request side plus external program-memory bus pins of the code fetch unit.
interface xcode_fetch_if;
    import mcu51_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              rdy;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ALE;
    logic              PSEN;
    logic [DATA_W-1:0] p0_out;
    logic              p0_oe;
    logic [DATA_W-1:0] p0_in;
    logic [DATA_W-1:0] p2_out;

    // slave: the fetch unit itself
    modport slave (
        input  req, addr, p0_in,
        output rdy, valid, data, ALE, PSEN, p0_out, p0_oe, p2_out
    );

    // master: control unit and external ROM model
    modport master (
        output req, addr, p0_in,
        input  rdy, valid, data, ALE, PSEN, p0_out, p0_oe, p2_out
    );
endinterface

// File: rtl/xbus_wait_cnt.sv
// PSEN wait-state down-counter: load on STROBE entry, decrement until zero.
module xbus_wait_cnt
    import mcu51_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/xcode_fetch.sv
// 8051-style external code fetch: ALE/PSEN sequencing with multiplexed P0 address/data.
module xcode_fetch
    import mcu51_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
)
(
    input  logic       clk,
    input  logic       reset,
    xcode_fetch_if.slave bus
);

    fetch_state_e state;
    fetch_state_e nxt;
    logic         load;
    logic         dec;
    logic         zero_c;
    logic         accept_c;
    logic         capture_c;

    xbus_wait_cnt u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .dec      (dec),
        .load_val (CNT_W'(WAIT_STATES)),
        .zero_c   (zero_c)
    );

    // next-state and counter control
    always_comb begin
        nxt  = state;
        load = 1'b0;
        dec  = 1'b0;
        case (state)
            ST_IDLE:   if (bus.req) nxt = ST_ADDR;
            ST_ADDR:   nxt = ST_LATCH;
            ST_LATCH: begin
                nxt  = ST_STROBE;
                load = 1'b1;
            end
            ST_STROBE: begin
                if (zero_c) nxt = ST_DONE;
                else        dec = 1'b1;
            end
            ST_DONE:   nxt = bus.req ? ST_ADDR : ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
    end

    assign accept_c  = ((state == ST_IDLE) || (state == ST_DONE)) && bus.req;
    assign capture_c = (state == ST_STROBE) && zero_c;

    // pad and status outputs are decoded from the next state so they change with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bus.ALE    <= 1'b0;
            bus.PSEN   <= PSEN_OFF;
            bus.p0_oe  <= 1'b0;
            bus.p0_out <= PORT_IDLE;
            bus.p2_out <= PORT_IDLE;
            bus.valid  <= 1'b0;
            bus.data   <= '0;
            bus.rdy    <= 1'b1;
        end else begin
            state     <= nxt;
            bus.ALE   <= (nxt == ST_ADDR);
            bus.PSEN  <= (nxt == ST_STROBE) ? ~PSEN_OFF : PSEN_OFF;
            bus.p0_oe <= (nxt == ST_ADDR) || (nxt == ST_LATCH);
            bus.valid <= (nxt == ST_DONE);
            bus.rdy   <= (nxt == ST_IDLE) || (nxt == ST_DONE);
            if (accept_c) begin
                bus.p0_out <= bus.addr[7:0];
                bus.p2_out <= bus.addr[15:8];
            end
            if (capture_c) begin
                bus.data <= bus.p0_in;
            end
        end
    end

endmodule

// File: tb/tb_xcode_fetch.sv
// Directed bench for xcode_fetch with WAIT_STATES = 1, 0 and 7.
module tb_xcode_fetch;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    xcode_fetch_if bus_a ();
    xcode_fetch_if bus_b ();
    xcode_fetch_if bus_c ();

    xcode_fetch #(.WAIT_STATES(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    xcode_fetch #(.WAIT_STATES(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    xcode_fetch #(.WAIT_STATES(7)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // bus-contention and ALE/PSEN overlap must never occur on any unit
    always @(negedge clk) begin
        chk("a_oe_psen",  16'(bus_a.p0_oe && !bus_a.PSEN), 16'd0);
        chk("a_ale_psen", 16'(bus_a.ALE   && !bus_a.PSEN), 16'd0);
        chk("b_oe_psen",  16'(bus_b.p0_oe && !bus_b.PSEN), 16'd0);
        chk("b_ale_psen", 16'(bus_b.ALE   && !bus_b.PSEN), 16'd0);
        chk("c_oe_psen",  16'(bus_c.p0_oe && !bus_c.PSEN), 16'd0);
        chk("c_ale_psen", 16'(bus_c.ALE   && !bus_c.PSEN), 16'd0);
    end

    initial begin
        int psen_b, psen_c, vld_b, vld_c;
        logic exp_v;

        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus_a.req = 1'b0; bus_a.addr = '0; bus_a.p0_in = '0;
        bus_b.req = 1'b0; bus_b.addr = '0; bus_b.p0_in = '0;
        bus_c.req = 1'b0; bus_c.addr = '0; bus_c.p0_in = '0;

        // reset values
        step(); step();
        chk("rst_ale",    16'(bus_a.ALE),    16'd0);
        chk("rst_psen",   16'(bus_a.PSEN),   16'd1);
        chk("rst_oe",     16'(bus_a.p0_oe),  16'd0);
        chk("rst_p0",     16'(bus_a.p0_out), 16'h00FF);
        chk("rst_p2",     16'(bus_a.p2_out), 16'h00FF);
        chk("rst_valid",  16'(bus_a.valid),  16'd0);
        chk("rst_data",   16'(bus_a.data),   16'h0000);
        chk("rst_rdy",    16'(bus_a.rdy),    16'd1);

        // single fetch 0x1234, request accepted on the first edge after reset release
        reset = 1'b1;
        bus_a.req = 1'b1; bus_a.addr = 16'h1234;
        step();
        chk("s1_ale",  16'(bus_a.ALE),    16'd1);
        chk("s1_p0",   16'(bus_a.p0_out), 16'h0034);
        chk("s1_p2",   16'(bus_a.p2_out), 16'h0012);
        chk("s1_oe",   16'(bus_a.p0_oe),  16'd1);
        chk("s1_psen", 16'(bus_a.PSEN),   16'd1);
        chk("s1_rdy",  16'(bus_a.rdy),    16'd0);
        bus_a.req = 1'b0; bus_a.addr = 16'h5555;
        step();
        chk("s2_ale",  16'(bus_a.ALE),    16'd0);
        chk("s2_oe",   16'(bus_a.p0_oe),  16'd1);
        chk("s2_p0",   16'(bus_a.p0_out), 16'h0034);
        chk("s2_psen", 16'(bus_a.PSEN),   16'd1);
        bus_a.p0_in = 8'h5A;
        step();
        chk("s3_psen", 16'(bus_a.PSEN),   16'd0);
        chk("s3_oe",   16'(bus_a.p0_oe),  16'd0);
        chk("s3_p2",   16'(bus_a.p2_out), 16'h0012);
        bus_a.req = 1'b1; bus_a.p0_in = 8'hA5;
        step();
        chk("s4_psen", 16'(bus_a.PSEN),   16'd0);
        chk("s4_valid",16'(bus_a.valid),  16'd0);
        bus_a.req = 1'b0;
        step();
        chk("s5_valid",16'(bus_a.valid),  16'd1);
        chk("s5_data", 16'(bus_a.data),   16'h00A5);
        chk("s5_psen", 16'(bus_a.PSEN),   16'd1);
        chk("s5_rdy",  16'(bus_a.rdy),    16'd1);
        step();
        chk("s6_valid",16'(bus_a.valid),  16'd0);
        chk("s6_ale",  16'(bus_a.ALE),    16'd0);
        chk("s6_p2",   16'(bus_a.p2_out), 16'h0012);
        chk("s6_data", 16'(bus_a.data),   16'h00A5);
        step();
        chk("s7_ale",  16'(bus_a.ALE),    16'd0);
        chk("s7_rdy",  16'(bus_a.rdy),    16'd1);

        // back-to-back fetches 0x0000 then 0x0001 with req held high
        bus_a.req = 1'b1; bus_a.addr = 16'h0000;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_v = (c == 5) || (c == 10);
            chk($sformatf("b2b_valid_c%0d", c), 16'(bus_a.valid), 16'(exp_v));
            chk($sformatf("b2b_rdy_c%0d", c),   16'(bus_a.rdy),   16'(exp_v));
            if (c == 1) begin
                chk("b2b_p0_first", 16'(bus_a.p0_out), 16'h0000);
                bus_a.addr = 16'h0001;
            end
            if (c == 2)  chk("b2b_p0_hold", 16'(bus_a.p0_out), 16'h0000);
            if (c == 3)  bus_a.p0_in = 8'h02;
            if (c == 5)  chk("b2b_data0", 16'(bus_a.data), 16'h0002);
            if (c == 6) begin
                chk("b2b_ale2", 16'(bus_a.ALE),    16'd1);
                chk("b2b_p0_2", 16'(bus_a.p0_out), 16'h0001);
            end
            if (c == 8)  bus_a.p0_in = 8'h74;
            if (c == 10) begin
                chk("b2b_data1", 16'(bus_a.data), 16'h0074);
                bus_a.req = 1'b0;
            end
        end
        step();
        chk("b2b_idle_valid", 16'(bus_a.valid), 16'd0);
        chk("b2b_idle_ale",   16'(bus_a.ALE),   16'd0);

        // WAIT_STATES 0 and 7 at address 0xFFFF
        bus_b.req = 1'b1; bus_b.addr = 16'hFFFF; bus_b.p0_in = 8'hC3;
        bus_c.req = 1'b1; bus_c.addr = 16'hFFFF; bus_c.p0_in = 8'h3C;
        psen_b = 0; psen_c = 0; vld_b = 0; vld_c = 0;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1) begin
                chk("w0_p0", 16'(bus_b.p0_out), 16'h00FF);
                chk("w7_p0", 16'(bus_c.p0_out), 16'h00FF);
                bus_b.req = 1'b0;
                bus_c.req = 1'b0;
            end
            if (!bus_b.PSEN) psen_b++;
            if (!bus_c.PSEN) psen_c++;
            if (bus_b.valid) vld_b = (vld_b == 0) ? c : 99;
            if (bus_c.valid) vld_c = (vld_c == 0) ? c : 99;
        end
        chk("w0_psen_cycles", 16'(psen_b), 16'd1);
        chk("w7_psen_cycles", 16'(psen_c), 16'd8);
        chk("w0_valid_cycle", 16'(vld_b),  16'd4);
        chk("w7_valid_cycle", 16'(vld_c),  16'd11);
        chk("w0_p2",          16'(bus_b.p2_out), 16'h00FF);
        chk("w7_p2",          16'(bus_c.p2_out), 16'h00FF);
        chk("w0_data",        16'(bus_b.data),   16'h00C3);
        chk("w7_data",        16'(bus_c.data),   16'h003C);

        // reset asserted mid-STROBE aborts the fetch
        bus_a.req = 1'b1; bus_a.addr = 16'h2345; bus_a.p0_in = 8'h99;
        step();
        bus_a.req = 1'b0;
        step(); step();
        chk("ra_psen_pre", 16'(bus_a.PSEN), 16'd0);
        #1 reset = 1'b0;
        #1;
        chk("ra_psen", 16'(bus_a.PSEN),   16'd1);
        chk("ra_oe",   16'(bus_a.p0_oe),  16'd0);
        chk("ra_ale",  16'(bus_a.ALE),    16'd0);
        chk("ra_rdy",  16'(bus_a.rdy),    16'd1);
        chk("ra_p2",   16'(bus_a.p2_out), 16'h00FF);
        step();
        chk("ra_valid_held", 16'(bus_a.valid), 16'd0);
        reset = 1'b1;
        vld_b = 0;
        for (int c = 1; c <= 3; c++) begin
            step();
            if (bus_a.valid) vld_b++;
        end
        chk("ra_no_valid", 16'(vld_b), 16'd0);
        chk("ra_data",     16'(bus_a.data), 16'h0000);

        // next request after the abort fetches normally
        bus_a.req = 1'b1; bus_a.addr = 16'h4567; bus_a.p0_in = 8'h3C;
        step();
        chk("rn_ale", 16'(bus_a.ALE),    16'd1);
        chk("rn_p0",  16'(bus_a.p0_out), 16'h0067);
        chk("rn_p2",  16'(bus_a.p2_out), 16'h0045);
        bus_a.req = 1'b0;
        step(); step(); step(); step();
        chk("rn_valid", 16'(bus_a.valid), 16'd1);
        chk("rn_data",  16'(bus_a.data),  16'h003C);
        step();
        chk("rn_valid_end", 16'(bus_a.valid), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
